mult_div_unit: RTL and testbench



---
 rtl/mult_div_unit_pkg.sv | 29 ++
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mult_div_unit_sign_fix.sv | 26 ++
 rtl/mult_div_unit.sv | 183 ++++++++++++++++++
 tb/tb_mult_div_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared types for the multicycle multiply/divide unit: FSM state encoding,
// Booth recoding and the default datapath width.
package mult_div_unit_pkg;

   localparam int MD_WIDTH = 32;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MULT = 2'd1,
      MD_DIV  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

   typedef enum logic [1:0] {
      BOOTH_NOP = 2'd0,
      BOOTH_ADD = 2'd1,
      BOOTH_SUB = 2'd2
   } booth_op_e;

   // Radix-2 Booth recoding of the pair {Q[0], q_-1}.
   function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
      case ({q0, q_m1})
         2'b01:   return BOOTH_ADD;
         2'b10:   return BOOTH_SUB;
         default: return BOOTH_NOP;
      endcase
   endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control-unit side of the multiply/divide unit: start strobes, operands,
// Hi/Lo results and status.
interface mult_div_unit_if
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH
);

   logic             MULT_on;
   logic             DIV_on;
   logic [WIDTH-1:0] A_in;
   logic [WIDTH-1:0] B_in;
   logic [WIDTH-1:0] Hi_out;
   logic [WIDTH-1:0] Lo_out;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output MULT_on, DIV_on, A_in, B_in,
      input  Hi_out, Lo_out, busy, done, div_zero
   );

   modport slave (
      input  MULT_on, DIV_on, A_in, B_in,
      output Hi_out, Lo_out, busy, done, div_zero
   );

endinterface

// File: rtl/mult_div_unit_sign_fix.sv
// Combinational sign handling for the divide path: operand magnitudes going
// in, signed quotient/remainder coming out.
module md_sign_fix #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] a_mag,
   output logic [WIDTH:0]   b_mag,
   input  logic [WIDTH-1:0] quo_mag,
   input  logic [WIDTH-1:0] rem_mag,
   input  logic             a_neg,
   input  logic             b_neg,
   output logic [WIDTH-1:0] quo,
   output logic [WIDTH-1:0] rem
);

   // Read as unsigned, the WIDTH-bit magnitude of -2^(WIDTH-1) is exact.
   always_comb begin
      a_mag = a_in[WIDTH-1] ? -a_in : a_in;
      b_mag = {1'b0, (b_in[WIDTH-1] ? -b_in : b_in)};
      quo   = (a_neg ^ b_neg) ? -quo_mag : quo_mag;
      rem   = a_neg ? -rem_mag : rem_mag;
   end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) / divide (restoring) unit with
// registered Hi/Lo results, a one-cycle done pulse and a divide-by-zero flag.
module mult_div_unit
   import mult_div_unit_pkg::*;
#(
   parameter int WIDTH = MD_WIDTH,
   parameter int CNT_W = 6
) (
   input  logic           clk,
   input  logic           reset,
   mult_div_unit_if.slave bus
);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   acc_q, acc_d;     // Booth accumulator / partial remainder
   logic [WIDTH-1:0] q_q, q_d;         // multiplier / dividend-then-quotient
   logic             qm1_q, qm1_d;
   logic [WIDTH:0]   m_q, m_d;         // sign-extended multiplicand / divisor magnitude
   logic             a_neg_q, a_neg_d;
   logic             b_neg_q, b_neg_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             dz_q, dz_d;

   logic             last_step;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH:0]   booth_acc;
   logic [WIDTH-1:0] booth_q;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic             div_neg;
   logic [WIDTH:0]   div_rem;
   logic [WIDTH-1:0] div_quo;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH:0]   b_mag;
   logic [WIDTH-1:0] fix_quo;
   logic [WIDTH-1:0] fix_rem;

   assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

   // One Booth step: add/subtract in WIDTH+1 bits, then arithmetic shift right.
   always_comb begin
      case (booth_decode(q_q[0], qm1_q))
         BOOTH_ADD: booth_sum = acc_q + m_q;
         BOOTH_SUB: booth_sum = acc_q - m_q;
         default:   booth_sum = acc_q;
      endcase
      booth_acc = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      booth_q   = {booth_sum[0], q_q[WIDTH-1:1]};
   end

   // One restoring step: the extra top bit of div_diff is the borrow.
   always_comb begin
      div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {1'b0, m_q};
      div_neg   = div_diff[WIDTH+1];
      div_rem   = div_neg ? div_shift : div_diff[WIDTH:0];
      div_quo   = {q_q[WIDTH-2:0], ~div_neg};
   end

   md_sign_fix #(
      .WIDTH (WIDTH)
   ) u_sign_fix (
      .a_in    (bus.A_in),
      .b_in    (bus.B_in),
      .a_mag   (a_mag),
      .b_mag   (b_mag),
      .quo_mag (div_quo),
      .rem_mag (div_rem[WIDTH-1:0]),
      .a_neg   (a_neg_q),
      .b_neg   (b_neg_q),
      .quo     (fix_quo),
      .rem     (fix_rem)
   );

   always_comb begin
      // NOTE: every _d gets a default first, so no path through the case leaves one unassigned (no latches).
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      q_d     = q_q;
      qm1_d   = qm1_q;
      m_d     = m_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      dz_d    = 1'b0;

      case (state_q)
         MD_IDLE: begin
            cnt_d = '0;
            if (bus.MULT_on) begin
               state_d = MD_MULT;
               acc_d   = '0;
               q_d     = bus.B_in;
               qm1_d   = 1'b0;
               m_d     = {bus.A_in[WIDTH-1], bus.A_in};
            end else if (bus.DIV_on) begin
               if (bus.B_in == '0) begin
                  state_d = MD_DONE;
                  dz_d    = 1'b1;
               end else begin
                  state_d = MD_DIV;
                  acc_d   = '0;
                  q_d     = a_mag;
                  m_d     = b_mag;
                  a_neg_d = bus.A_in[WIDTH-1];
                  b_neg_d = bus.B_in[WIDTH-1];
               end
            end
         end
         MD_MULT: begin
            acc_d = booth_acc;
            q_d   = booth_q;
            qm1_d = q_q[0];
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
               state_d = MD_DONE;
               hi_d    = booth_acc[WIDTH-1:0];
               lo_d    = booth_q;
            end
         end
         MD_DIV: begin
            acc_d = div_rem;
            q_d   = div_quo;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
               state_d = MD_DONE;
               hi_d    = fix_rem;
               lo_d    = fix_quo;
            end
         end
         default: state_d = MD_IDLE;
      endcase

      busy_d = (state_d != MD_IDLE);
      done_d = (state_d == MD_DONE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= MD_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         qm1_q   <= 1'b0;
         m_q     <= '0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         q_q     <= q_d;
         qm1_q   <= qm1_d;
         m_q     <= m_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         dz_q    <= dz_d;
      end
   end

   assign bus.Hi_out   = hi_q;
   assign bus.Lo_out   = lo_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: constant vector table, model-checked
// random operands, and hand-written sequences for DONE/back-to-back/reset.
module tb_mult_div_unit;

   localparam int W = 32;

   typedef enum {OP_MUL, OP_DIV, OP_BOTH} op_e;

   typedef struct {
      op_e          op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } vec_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(W)) bus ();

   mult_div_unit #(
      .WIDTH (W),
      .CNT_W (6)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   vec_t exp_q[$];
   vec_t table_v[13];
   int   n_cmp    = 0;
   int   n_err    = 0;
   int   done_cnt = 0;

   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t model(input op_e op, input logic [W-1:0] a, input logic [W-1:0] b);
      vec_t        v;
      longint      p;
      longint      r;
      logic [63:0] pv;
      logic [63:0] rv;
      v.op = op; v.a = a; v.b = b; v.dz = 1'b0;
      if (op == OP_DIV) begin
         p  = longint'($signed(a)) / longint'($signed(b));
         r  = longint'($signed(a)) % longint'($signed(b));
         pv = p;
         rv = r;
         v.lo = pv[W-1:0];
         v.hi = rv[W-1:0];
      end else begin
         p  = longint'($signed(a)) * longint'($signed(b));
         pv = p;
         v.hi = pv[2*W-1:W];
         v.lo = pv[W-1:0];
      end
      return v;
   endfunction

   // Queue the expectation, drive one strobe cycle, then scramble the operands.
   task automatic issue(input vec_t v);
      exp_q.push_back(v);
      @(negedge clk);
      bus.MULT_on = (v.op != OP_DIV);
      bus.DIV_on  = (v.op != OP_MUL);
      bus.A_in    = v.a;
      bus.B_in    = v.b;
      @(posedge clk); #1;
      bus.MULT_on = 1'b0;
      bus.DIV_on  = 1'b0;
      bus.A_in    = $urandom;
      bus.B_in    = $urandom;
   endtask

   // Called just after the acceptance edge; returns at the negedge of the done cycle.
   task automatic collect(input string name);
      vec_t v;
      int   lat     = 0;
      int   busy_n  = 0;
      int   exp_lat;
      bit   seen    = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         lat++;
         if (bus.busy === 1'b1) busy_n++;
         if (bus.done === 1'b1) seen = 1'b1;
      end
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL %s: scoreboard empty, got done, expected a queued result", name);
      end else begin
         v = exp_q.pop_front();
         if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL %s timeout: got no done in %0d cycles, expected done", name, lat);
         end else begin
            exp_lat = v.dz ? 1 : W + 1;
            check({name, " latency"}, 64'(lat), 64'(exp_lat));
            check({name, " busy"}, 64'(busy_n), 64'(exp_lat));
            check({name, " hi"}, 64'(bus.Hi_out), 64'(v.hi));
            check({name, " lo"}, 64'(bus.Lo_out), 64'(v.lo));
            check({name, " div_zero"}, 64'(bus.div_zero), 64'(v.dz));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, expected finish within 2 ms");
      $fatal(1);
   end

   initial begin
      int base;

      table_v[0]  = '{OP_MUL,  32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      table_v[1]  = '{OP_MUL,  32'h80000000,  32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      table_v[2]  = '{OP_DIV,  32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      table_v[3]  = '{OP_DIV,  32'd7,         32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
      table_v[4]  = '{OP_MUL,  32'h12345678,  32'd9,        32'h00000000, 32'hA3D70A38, 1'b0};
      table_v[5]  = '{OP_DIV,  32'd5,         32'd0,        32'h00000000, 32'hA3D70A38, 1'b1};
      table_v[6]  = '{OP_DIV,  32'h80000000,  32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      table_v[7]  = '{OP_MUL,  32'd0,         32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b0};
      table_v[8]  = '{OP_MUL,  32'hFFFFFFFF,  32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
      table_v[9]  = '{OP_DIV,  32'd100,       32'd7,        32'd2,        32'd14,       1'b0};
      table_v[10] = '{OP_DIV,  32'h80000000,  32'd1,        32'h00000000, 32'h80000000, 1'b0};
      table_v[11] = '{OP_MUL,  32'h7FFFFFFF,  32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
      table_v[12] = '{OP_BOTH, 32'd6,         32'd0,        32'h00000000, 32'h00000000, 1'b0};

      reset       = 1'b1;
      bus.MULT_on = 1'b0;
      bus.DIV_on  = 1'b0;
      bus.A_in    = '0;
      bus.B_in    = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("reset hi", 64'(bus.Hi_out), 64'd0);
      check("reset lo", 64'(bus.Lo_out), 64'd0);
      check("reset busy", 64'(bus.busy), 64'd0);
      check("reset done", 64'(bus.done), 64'd0);
      check("reset div_zero", 64'(bus.div_zero), 64'd0);

      for (int i = 0; i < 13; i++) begin
         issue(table_v[i]);
         collect($sformatf("vec%0d", i));
      end

      for (int i = 0; i < 8; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         op_e          op;
         a  = $urandom;
         b  = $urandom;
         op = (i % 2 == 0) ? OP_MUL : OP_DIV;
         if (op == OP_DIV && b == '0) b = 32'd3;
         issue(model(op, a, b));
         collect($sformatf("rand%0d", i));
      end

      // Strobe held from the DONE cycle: ignored in DONE, accepted in the first IDLE cycle.
      issue(model(OP_MUL, 32'd3, 32'd5));
      collect("b2b first");
      bus.MULT_on = 1'b1;
      bus.A_in    = 32'd2;
      bus.B_in    = 32'hFFFFFFFF;
      exp_q.push_back('{OP_MUL, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
      @(negedge clk);
      check("b2b idle busy", 64'(bus.busy), 64'd0);
      check("b2b idle done", 64'(bus.done), 64'd0);
      @(posedge clk); #1;
      bus.MULT_on = 1'b0;
      bus.A_in    = $urandom;
      bus.B_in    = $urandom;
      collect("b2b second");

      // Reset in the middle of a multiply, with ignored strobes at cycle 5.
      @(negedge clk);
      bus.MULT_on = 1'b1;
      bus.A_in    = 32'h1234;
      bus.B_in    = 32'h5678;
      @(posedge clk); #1;
      bus.MULT_on = 1'b0;
      base = done_cnt;
      repeat (4) @(posedge clk);
      #1;
      bus.MULT_on = 1'b1;
      bus.DIV_on  = 1'b1;
      bus.B_in    = '0;
      @(posedge clk); #1;
      bus.MULT_on = 1'b0;
      bus.DIV_on  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("abort busy before reset", 64'(bus.busy), 64'd1);
      check("abort no early done", 64'(done_cnt), 64'(base));
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort hi", 64'(bus.Hi_out), 64'd0);
      check("abort lo", 64'(bus.Lo_out), 64'd0);
      check("abort busy", 64'(bus.busy), 64'd0);
      check("abort done", 64'(bus.done), 64'd0);
      check("abort div_zero", 64'(bus.div_zero), 64'd0);
      repeat (40) @(negedge clk);
      #1;
      check("abort no done pulse", 64'(done_cnt), 64'(base));

      issue('{OP_MUL, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0});
      collect("after abort");

      check("scoreboard drained", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
